load_store_unit_nb: RTL and testbench

Non-blocking load-store unit for the execute stage. Accepts memory micro-ops from decode and keeps up to `p_max_in_flight` memory requests outstanding. It supports byte, half and word loads with sign or zero extension, plus byte, half and word stores. Completed operations return to writeback in program order.

---
 rtl/load_store_unit_nb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_load_store_unit_nb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_nb.sv
// load_store_unit_nb
// Non-blocking load/store unit. Decode ops are forwarded to memory in the same
// cycle and tracked in an in-order FIFO. Responses come back in request order.
// Each response is sign/zero extended and held in a single writeback register
// until writeback accepts it.
//
// uop encoding on d_uop:
//   0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw. Values 8..15 are
//   unsupported and are never accepted.
//
// mem op encoding: 0 read, 1 write. A len of 0 means a 4-byte access.
module load_store_unit_nb #(
   parameter int p_seq_num_bits  = 5,
   parameter int p_opaq_bits     = 8,
   parameter int p_max_in_flight = 4
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      d_val,
   output logic                      d_rdy,
   input  logic [31:0]               d_pc,
   input  logic [p_seq_num_bits-1:0] d_seq_num,
   input  logic [31:0]               d_op1,
   input  logic [31:0]               d_op2,
   input  logic [31:0]               d_op3,
   input  logic [4:0]                d_waddr,
   input  logic [3:0]                d_uop,

   output logic                      w_val,
   input  logic                      w_rdy,
   output logic [31:0]               w_pc,
   output logic [p_seq_num_bits-1:0] w_seq_num,
   output logic [4:0]                w_waddr,
   output logic [31:0]               w_wdata,
   output logic                      w_wen,

   output logic                      mem_req_val,
   input  logic                      mem_req_rdy,
   output logic                      mem_req_op,
   output logic [p_opaq_bits-1:0]    mem_req_opaque,
   output logic [31:0]               mem_req_addr,
   output logic [1:0]                mem_req_len,
   output logic [31:0]               mem_req_data,

   input  logic                      mem_resp_val,
   output logic                      mem_resp_rdy,
   input  logic                      mem_resp_op,
   input  logic [p_opaq_bits-1:0]    mem_resp_opaque,
   input  logic [1:0]                mem_resp_len,
   input  logic [31:0]               mem_resp_data
);

   localparam logic [3:0] UOP_LB  = 4'd0;
   localparam logic [3:0] UOP_LH  = 4'd1;
   localparam logic [3:0] UOP_LW  = 4'd2;
   localparam logic [3:0] UOP_LBU = 4'd3;
   localparam logic [3:0] UOP_LHU = 4'd4;
   localparam logic [3:0] UOP_SB  = 4'd5;
   localparam logic [3:0] UOP_SH  = 4'd6;
   localparam logic [3:0] UOP_SW  = 4'd7;

   // A depth of one still needs a 1-bit pointer; it simply never moves.
   localparam int PTR_W = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
   localparam int CNT_W = $clog2(p_max_in_flight + 1);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(p_max_in_flight - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(p_max_in_flight);

   logic [PTR_W-1:0]          head_q, head_d;
   logic [PTR_W-1:0]          tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;

   logic [31:0]               fifo_pc_q    [p_max_in_flight];
   logic [31:0]               fifo_pc_d    [p_max_in_flight];
   logic [p_seq_num_bits-1:0] fifo_seq_q   [p_max_in_flight];
   logic [p_seq_num_bits-1:0] fifo_seq_d   [p_max_in_flight];
   logic [4:0]                fifo_waddr_q [p_max_in_flight];
   logic [4:0]                fifo_waddr_d [p_max_in_flight];
   logic [3:0]                fifo_uop_q   [p_max_in_flight];
   logic [3:0]                fifo_uop_d   [p_max_in_flight];

   logic                      wb_val_q, wb_val_d;
   logic [31:0]               wb_pc_q, wb_pc_d;
   logic [p_seq_num_bits-1:0] wb_seq_q, wb_seq_d;
   logic [4:0]                wb_waddr_q, wb_waddr_d;
   logic [31:0]               wb_wdata_q, wb_wdata_d;
   logic                      wb_wen_q, wb_wen_d;

   logic        uop_ok;
   logic        req_store;
   logic [1:0]  req_len;
   logic [31:0] store_data;
   logic        full;
   logic        issue;
   logic        retire;
   logic [3:0]  head_uop;
   logic        head_store;
   logic [1:0]  head_len;
   logic [31:0] load_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [1:0] uop_len(input logic [3:0] u);
      case (u)
         UOP_LB, UOP_LBU, UOP_SB: return 2'd1;
         UOP_LH, UOP_LHU, UOP_SH: return 2'd2;
         default:                 return 2'd0;
      endcase
   endfunction

   function automatic logic uop_is_store(input logic [3:0] u);
      return (u == UOP_SB) || (u == UOP_SH) || (u == UOP_SW);
   endfunction

   // Decode the incoming op and shape the store data into the low bytes.
   always_comb begin
      uop_ok     = (d_uop <= UOP_SW);
      req_store  = uop_is_store(d_uop);
      req_len    = uop_len(d_uop);
      store_data = d_op3;
      case (req_len)
         2'd1:    store_data = {24'h0, d_op3[7:0]};
         2'd2:    store_data = {16'h0, d_op3[15:0]};
         default: store_data = d_op3;
      endcase
   end

   // Extend response data according to the op sitting at the FIFO head.
   always_comb begin
      head_uop   = fifo_uop_q[head_q];
      head_store = uop_is_store(head_uop);
      head_len   = uop_len(head_uop);
      load_data  = mem_resp_data;
      case (head_uop)
         UOP_LB:  load_data = {{24{mem_resp_data[7]}}, mem_resp_data[7:0]};
         UOP_LBU: load_data = {24'h0, mem_resp_data[7:0]};
         UOP_LH:  load_data = {{16{mem_resp_data[15]}}, mem_resp_data[15:0]};
         UOP_LHU: load_data = {16'h0, mem_resp_data[15:0]};
         default: load_data = mem_resp_data;
      endcase
   end

   // Full is based on the registered count only, so a pop never frees a slot
   // for a push in the same cycle.
   assign full           = (count_q == DEPTH_CNT);
   assign d_rdy          = mem_req_rdy & ~full & uop_ok & ~rst;
   assign mem_req_val    = d_val & ~full & uop_ok & ~rst;
   assign mem_req_op     = req_store;
   assign mem_req_opaque = p_opaq_bits'(tail_q);
   assign mem_req_addr   = d_op1 + d_op2;
   assign mem_req_len    = req_len;
   assign mem_req_data   = req_store ? store_data : 32'h0;
   assign mem_resp_rdy   = rst | ~wb_val_q | w_rdy;

   assign issue  = d_val & d_rdy;
   assign retire = mem_resp_val & mem_resp_rdy & ~rst;

   assign w_val     = wb_val_q & ~rst;
   assign w_pc      = wb_pc_q;
   assign w_seq_num = wb_seq_q;
   assign w_waddr   = wb_waddr_q;
   assign w_wdata   = wb_wdata_q;
   assign w_wen     = wb_wen_q;

   // Next-state for the tracking FIFO and the writeback register.
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      fifo_pc_d    = fifo_pc_q;
      fifo_seq_d   = fifo_seq_q;
      fifo_waddr_d = fifo_waddr_q;
      fifo_uop_d   = fifo_uop_q;
      wb_val_d     = wb_val_q;
      wb_pc_d      = wb_pc_q;
      wb_seq_d     = wb_seq_q;
      wb_waddr_d   = wb_waddr_q;
      wb_wdata_d   = wb_wdata_q;
      wb_wen_d     = wb_wen_q;

      if (issue) begin
         fifo_pc_d[tail_q]    = d_pc;
         fifo_seq_d[tail_q]   = d_seq_num;
         fifo_waddr_d[tail_q] = d_waddr;
         fifo_uop_d[tail_q]   = d_uop;
         tail_d               = ptr_inc(tail_q);
      end

      if (retire) begin
         head_d     = ptr_inc(head_q);
         wb_val_d   = 1'b1;
         wb_pc_d    = fifo_pc_q[head_q];
         wb_seq_d   = fifo_seq_q[head_q];
         wb_waddr_d = head_store ? 5'd0 : fifo_waddr_q[head_q];
         wb_wdata_d = head_store ? 32'h0 : load_data;
         wb_wen_d   = ~head_store;
      end else if (wb_val_q && w_rdy) begin
         wb_val_d = 1'b0;
      end

      case ({issue, retire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state and writeback register, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         wb_val_q   <= 1'b0;
         wb_pc_q    <= '0;
         wb_seq_q   <= '0;
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
         wb_wen_q   <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         wb_val_q   <= wb_val_d;
         wb_pc_q    <= wb_pc_d;
         wb_seq_q   <= wb_seq_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
         wb_wen_q   <= wb_wen_d;
      end
   end

   // Tracking payload has no reset: a slot is only read after it was pushed.
   always_ff @(posedge clk) begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_seq_q   <= fifo_seq_d;
      fifo_waddr_q <= fifo_waddr_d;
      fifo_uop_q   <= fifo_uop_d;
   end

   // Protocol checks on the decode and memory interfaces.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (d_val) begin
            a_uop_supported: assert (uop_ok);
         end
         if (mem_resp_val) begin
            a_resp_not_empty: assert (count_q != '0);
         end
         if (retire) begin
            a_resp_opaque: assert (mem_resp_opaque == p_opaq_bits'(head_q));
            a_resp_op:     assert (mem_resp_op == head_store);
            a_resp_len:    assert (mem_resp_len == head_len);
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit_nb.sv
// Bench for load_store_unit_nb: directed ops with a scoreboard on writeback and
// a small in-order memory model with configurable response delay.
module tb_load_store_unit_nb;

   localparam int SEQ_W = 5;
   localparam int OPQ_W = 8;
   localparam int DEPTH = 2;

   localparam logic [3:0] LB  = 4'd0;
   localparam logic [3:0] LH  = 4'd1;
   localparam logic [3:0] LW  = 4'd2;
   localparam logic [3:0] LBU = 4'd3;
   localparam logic [3:0] LHU = 4'd4;
   localparam logic [3:0] SB  = 4'd5;
   localparam logic [3:0] SH  = 4'd6;
   localparam logic [3:0] SW  = 4'd7;

   logic             clk = 1'b0;
   logic             rst;
   logic             d_val, d_rdy;
   logic [31:0]      d_pc, d_op1, d_op2, d_op3;
   logic [SEQ_W-1:0] d_seq_num;
   logic [4:0]       d_waddr;
   logic [3:0]       d_uop;
   logic             w_val, w_rdy;
   logic [31:0]      w_pc, w_wdata;
   logic [SEQ_W-1:0] w_seq_num;
   logic [4:0]       w_waddr;
   logic             w_wen;
   logic             mem_req_val, mem_req_rdy, mem_req_op;
   logic [OPQ_W-1:0] mem_req_opaque;
   logic [31:0]      mem_req_addr, mem_req_data;
   logic [1:0]       mem_req_len;
   logic             mem_resp_val, mem_resp_rdy, mem_resp_op;
   logic [OPQ_W-1:0] mem_resp_opaque;
   logic [1:0]       mem_resp_len;
   logic [31:0]      mem_resp_data;

   load_store_unit_nb #(
      .p_seq_num_bits (SEQ_W),
      .p_opaq_bits    (OPQ_W),
      .p_max_in_flight(DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .d_val          (d_val),
      .d_rdy          (d_rdy),
      .d_pc           (d_pc),
      .d_seq_num      (d_seq_num),
      .d_op1          (d_op1),
      .d_op2          (d_op2),
      .d_op3          (d_op3),
      .d_waddr        (d_waddr),
      .d_uop          (d_uop),
      .w_val          (w_val),
      .w_rdy          (w_rdy),
      .w_pc           (w_pc),
      .w_seq_num      (w_seq_num),
      .w_waddr        (w_waddr),
      .w_wdata        (w_wdata),
      .w_wen          (w_wen),
      .mem_req_val    (mem_req_val),
      .mem_req_rdy    (mem_req_rdy),
      .mem_req_op     (mem_req_op),
      .mem_req_opaque (mem_req_opaque),
      .mem_req_addr   (mem_req_addr),
      .mem_req_len    (mem_req_len),
      .mem_req_data   (mem_req_data),
      .mem_resp_val   (mem_resp_val),
      .mem_resp_rdy   (mem_resp_rdy),
      .mem_resp_op    (mem_resp_op),
      .mem_resp_opaque(mem_resp_opaque),
      .mem_resp_len   (mem_resp_len),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endfunction

   typedef struct {
      logic [31:0]      pc;
      logic [SEQ_W-1:0] seq;
      logic [4:0]       waddr;
      logic [31:0]      wdata;
      logic             wen;
   } wb_exp_t;

   typedef struct {
      logic [OPQ_W-1:0] opaque;
      logic [1:0]       len;
      logic             op;
      logic [31:0]      data;
      int               due;
   } resp_t;

   wb_exp_t    exp_q[$];
   resp_t      rq[$];
   logic [7:0] mem_arr [0:4095];
   int         cyc       = 0;
   int         mem_delay = 1;
   int         w_delay   = 0;
   int         wcnt      = 0;
   int         exp_opq   = 0;
   logic [SEQ_W-1:0] seq = 5'd1;

   // Memory model: observe handshakes mid-cycle; they complete at the next edge.
   resp_t r_new;
   int    nbytes;
   always @(negedge clk) begin
      if (rst) begin
         rq.delete();
         exp_opq = 0;
      end else begin
         if (mem_resp_val && mem_resp_rdy) void'(rq.pop_front());
         if (mem_req_val && mem_req_rdy) begin
            check("req_opaque", 32'(mem_req_opaque), 32'(exp_opq));
            exp_opq = (exp_opq + 1) % DEPTH;
            nbytes = (mem_req_len == 2'd0) ? 4 : int'(mem_req_len);
            r_new.opaque = mem_req_opaque;
            r_new.len    = mem_req_len;
            r_new.op     = mem_req_op;
            r_new.data   = 32'h0;
            r_new.due    = cyc + mem_delay;
            if (mem_req_op) begin
               if (nbytes < 4)
                  check("store_data_mask", mem_req_data, mem_req_data & ((32'h1 << (8 * nbytes)) - 32'h1));
               for (int i = 0; i < nbytes; i++)
                  mem_arr[(int'(mem_req_addr[11:0]) + i) & 4095] = mem_req_data[8*i +: 8];
            end else begin
               for (int i = 0; i < nbytes; i++)
                  r_new.data[8*i +: 8] = mem_arr[(int'(mem_req_addr[11:0]) + i) & 4095];
            end
            rq.push_back(r_new);
         end
      end
   end

   // Drive memory responses and writeback ready just after each edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         mem_resp_val    = 1'b1;
         mem_resp_opaque = rq[0].opaque;
         mem_resp_len    = rq[0].len;
         mem_resp_op     = rq[0].op;
         mem_resp_data   = rq[0].data;
      end else begin
         mem_resp_val = 1'b0;
      end
      if (w_delay == 0) begin
         w_rdy = 1'b1;
      end else begin
         if (w_val) wcnt++;
         w_rdy = (wcnt > w_delay);
      end
   end

   // Writeback monitor: pops the scoreboard on each W handshake.
   logic        stall_prev = 1'b0;
   logic [31:0] prev_pc, prev_wdata;
   logic [4:0]  prev_waddr;
   logic [SEQ_W-1:0] prev_seq;
   logic        prev_wen;
   wb_exp_t     e_mon;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         wcnt       = 0;
      end else begin
         if (stall_prev) begin
            check("w_hold_val",   32'(w_val),     32'h1);
            check("w_hold_wdata", w_wdata,        prev_wdata);
            check("w_hold_seq",   32'(w_seq_num), 32'(prev_seq));
            check("w_hold_wen",   32'(w_wen),     32'(prev_wen));
         end
         if (w_val && w_rdy) begin
            wcnt = 0;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL w_unexpected: actual seq=%0d wdata=0x%08h required no completion", w_seq_num, w_wdata);
            end else begin
               e_mon = exp_q.pop_front();
               check("w_seq",   32'(w_seq_num), 32'(e_mon.seq));
               check("w_pc",    w_pc,           e_mon.pc);
               check("w_waddr", 32'(w_waddr),   32'(e_mon.waddr));
               check("w_wdata", w_wdata,        e_mon.wdata);
               check("w_wen",   32'(w_wen),     32'(e_mon.wen));
            end
         end
         stall_prev = w_val && !w_rdy;
         prev_pc    = w_pc;
         prev_wdata = w_wdata;
         prev_waddr = w_waddr;
         prev_seq   = w_seq_num;
         prev_wen   = w_wen;
      end
   end

   // Present one op; called just after an edge, returns just after its handshake edge.
   task automatic issue(input logic [3:0] uop, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [31:0] op3, input logic [4:0] waddr,
                        input logic [31:0] exp_wdata, input bit expect_stall);
      wb_exp_t e;
      int      waited = 0;
      bit      is_st;
      is_st     = (uop == SB) || (uop == SH) || (uop == SW);
      d_uop     = uop;
      d_op1     = op1;
      d_op2     = op2;
      d_op3     = op3;
      d_waddr   = waddr;
      d_seq_num = seq;
      d_pc      = 32'h0000_1000 + {25'h0, seq, 2'b00};
      d_val     = 1'b1;
      @(negedge clk);
      if (expect_stall) check("d_rdy_when_full", 32'(d_rdy), 32'h0);
      while (!d_rdy && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!d_rdy) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: actual d_rdy=0 required 1 within 200 cycles (seq %0d)", seq);
      end else begin
         e.pc    = d_pc;
         e.seq   = seq;
         e.waddr = is_st ? 5'd0 : waddr;
         e.wdata = is_st ? 32'h0 : exp_wdata;
         e.wen   = !is_st;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      d_val = 1'b0;
      seq   = seq + 5'd1;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: actual %0d completions pending required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input int a, input logic [31:0] v);
      for (int i = 0; i < 4; i++) mem_arr[a + i] = v[8*i +: 8];
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem_arr[i] = 8'h00;
      put_word(32'h100, 32'hDEADBEEF);
      put_word(32'h200, 32'h000080FF);
      put_word(32'h500, 32'hA0000000);
      put_word(32'h504, 32'hA0000001);
      put_word(32'h508, 32'hA0000002);
      put_word(32'h50C, 32'hA0000003);
      rst             = 1'b1;
      w_rdy           = 1'b1;
      mem_req_rdy     = 1'b1;
      mem_resp_val    = 1'b0;
      mem_resp_op     = 1'b0;
      mem_resp_opaque = '0;
      mem_resp_len    = 2'd0;
      mem_resp_data   = 32'h0;
      d_val           = 1'b1;
      d_uop           = LW;
      d_op1           = 32'h100;
      d_op2           = 32'h0;
      d_op3           = 32'h0;
      d_waddr         = 5'd1;
      d_seq_num       = '0;
      d_pc            = 32'h0;

      // Reset state, with a valid op presented to make the gating visible.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_w_val",        32'(w_val),         32'h0);
      check("rst_d_rdy",        32'(d_rdy),         32'h0);
      check("rst_mem_req_val",  32'(mem_req_val),   32'h0);
      check("rst_mem_resp_rdy", 32'(mem_resp_rdy),  32'h1);
      check("rst_count",        32'(dut.count_q),   32'h0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      d_val = 1'b0;

      // Single lw: 0x0F0 + 0x10 = 0x100.
      issue(LW, 32'h0F0, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0);
      drain();

      // Sign and zero extension from word 0x000080FF.
      issue(LB,  32'h200, 32'h0, 32'h0, 5'd6, 32'hFFFFFFFF, 1'b0);
      issue(LBU, 32'h200, 32'h0, 32'h0, 5'd7, 32'h000000FF, 1'b0);
      issue(LH,  32'h1F0, 32'h10, 32'h0, 5'd8, 32'hFFFF80FF, 1'b0);
      issue(LHU, 32'h200, 32'h0, 32'h0, 5'd9, 32'h000080FF, 1'b0);
      drain();

      // Stores then a load covering both (upper op3 bits must be dropped).
      issue(SB, 32'h300, 32'h1, 32'hFFFFFFAB, 5'd10, 32'h0, 1'b0);
      issue(SH, 32'h300, 32'h2, 32'hFFFF1234, 5'd11, 32'h0, 1'b0);
      issue(LW, 32'h300, 32'h0, 32'h0,        5'd12, 32'h1234AB00, 1'b0);
      drain();

      // Full queue: slow memory, third op must see d_rdy low.
      mem_delay = 3;
      issue(LW, 32'h500, 32'h0, 32'h0, 5'd13, 32'hA0000000, 1'b0);
      issue(LW, 32'h500, 32'h4, 32'h0, 5'd14, 32'hA0000001, 1'b0);
      issue(LW, 32'h500, 32'h8, 32'h0, 5'd15, 32'hA0000002, 1'b1);
      issue(LW, 32'h500, 32'hC, 32'h0, 5'd16, 32'hA0000003, 1'b0);
      drain();

      // Writeback backpressure with mixed stores and loads.
      mem_delay = 1;
      w_delay   = 3;
      issue(SW,  32'h400, 32'h0, 32'h11111111, 5'd1, 32'h0,        1'b0);
      issue(LW,  32'h400, 32'h0, 32'h0,        5'd2, 32'h11111111, 1'b0);
      issue(SW,  32'h404, 32'h0, 32'hA5A5A5A5, 5'd3, 32'h0,        1'b0);
      issue(LW,  32'h404, 32'h0, 32'h0,        5'd4, 32'hA5A5A5A5, 1'b0);
      issue(SH,  32'h408, 32'h0, 32'hCAFEBEEF, 5'd5, 32'h0,        1'b0);
      issue(LHU, 32'h408, 32'h0, 32'h0,        5'd6, 32'h0000BEEF, 1'b0);
      issue(SB,  32'h40C, 32'h0, 32'h12345680, 5'd7, 32'h0,        1'b0);
      issue(LB,  32'h40C, 32'h0, 32'h0,        5'd8, 32'hFFFFFF80, 1'b0);
      drain();
      w_delay = 0;

      // Mid-stream reset with two loads outstanding.
      mem_delay = 10;
      issue(LW, 32'h100, 32'h0, 32'h0, 5'd20, 32'hDEADBEEF, 1'b0);
      issue(LW, 32'h200, 32'h0, 32'h0, 5'd21, 32'h000080FF, 1'b0);
      check("pre_rst_count", 32'(dut.count_q), 32'h2);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_w_val", 32'(w_val),       32'h0);
      check("post_rst_count", 32'(dut.count_q), 32'h0);
      @(posedge clk);
      #1;
      mem_delay = 1;
      issue(LW, 32'h0F0, 32'h10, 32'h0, 5'd22, 32'hDEADBEEF, 1'b0);
      drain();

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual simulation still running required finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
